// File: rtl/aibio_cdr_pkg.sv
// Shared types and sizing helpers for the CDR phase-detector vote filter.
package aibio_cdr_pkg;

  typedef enum logic [1:0] {
    DEC_NONE = 2'd0,
    DEC_UP   = 2'd1,
    DEC_DN   = 2'd2
  } cdr_dec_e;

  // Window sum range is +/- nch * 2^win_w, plus a sign bit.
  function automatic int acc_w(input int nch, input int win_w);
    return win_w + $clog2(nch + 1) + 1;
  endfunction

endpackage

// File: rtl/aibio_cdr_vote_sum.sv
// Combinational masked popcount: delta = 2*ones - active for one sample cycle.
module aibio_cdr_vote_sum #(
  parameter int NCH   = 4,
  parameter int ACC_W = 8
) (
  input  logic [NCH-1:0]          phdet,
  input  logic [NCH-1:0]          ch_mask,
  output logic signed [ACC_W-1:0] delta
);

  logic [ACC_W-1:0] ones;
  logic [ACC_W-1:0] act;

  always_comb begin
    ones = '0;
    act  = '0;
    for (int i = 0; i < NCH; i++) begin
      ones = ones + ACC_W'(phdet[i] & ch_mask[i]);
      act  = act + ACC_W'(ch_mask[i]);
    end
    delta = $signed((ones << 1) - act);
  end

endmodule

// File: rtl/aibio_cdr_phdet_filter.sv
// Windowed early/late vote filter for the RX CDR loop.
// Optional lock detector enabled by defining AIBIO_CDR_LOCK_DET_EN.
module aibio_cdr_phdet_filter
  import aibio_cdr_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int WIN_W    = 4,
  parameter int THR_W    = 8,
  parameter int LOCK_CNT = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_en,
  input  logic                          i_clr,
  input  logic [NCH-1:0]                i_phdet,
  input  logic [NCH-1:0]                i_ch_mask,
  input  logic [THR_W-1:0]              i_thr,
  output logic                          o_valid,
  output logic                          o_up,
  output logic                          o_dn,
  output logic [acc_w(NCH, WIN_W)-1:0]  o_acc,
  output logic                          o_lock
);

  localparam int ACC_W = acc_w(NCH, WIN_W);
  localparam int CMP_W = ((ACC_W > THR_W) ? ACC_W : THR_W) + 1;
  localparam logic [WIN_W-1:0] CNT_LAST = '1;

  if (LOCK_CNT < 1) begin : g_lock_cnt_check
    $error("LOCK_CNT must be at least 1");
  end

  logic [WIN_W-1:0]          cnt;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   delta;
  logic signed [ACC_W-1:0]   final_sum;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [CMP_W-1:0]   fin_x;
  logic signed [CMP_W-1:0]   thr_x;
  logic                      valid_q;
  logic                      window_close;
  cdr_dec_e                  dec_q;
  cdr_dec_e                  dec_next;

  aibio_cdr_vote_sum #(
    .NCH   (NCH),
    .ACC_W (ACC_W)
  ) u_vote_sum (
    .phdet   (i_phdet),
    .ch_mask (i_ch_mask),
    .delta   (delta)
  );

  assign final_sum    = acc + delta;
  assign window_close = i_en & ~i_clr & (cnt == CNT_LAST);
  assign fin_x = {{(CMP_W - ACC_W){final_sum[ACC_W-1]}}, final_sum};
  assign thr_x = $signed({{(CMP_W - THR_W){1'b0}}, i_thr});

  // Up wins when both compares hold (threshold zero, sum zero).
  always_comb begin
    dec_next = DEC_NONE;
    if (fin_x >= thr_x) begin
      dec_next = DEC_UP;
    end else if (fin_x <= -thr_x) begin
      dec_next = DEC_DN;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt     <= '0;
      acc     <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      dec_q   <= DEC_NONE;
    end else begin
      valid_q <= 1'b0;
      dec_q   <= DEC_NONE;
      if (i_clr) begin
        cnt <= '0;
        acc <= '0;
      end else if (window_close) begin
        cnt     <= '0;
        acc     <= '0;
        acc_q   <= final_sum;
        valid_q <= 1'b1;
        dec_q   <= dec_next;
      end else if (i_en) begin
        cnt <= cnt + WIN_W'(1);
        acc <= final_sum;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_up    = (dec_q == DEC_UP);
  assign o_dn    = (dec_q == DEC_DN);
  assign o_acc   = acc_q;

`ifdef AIBIO_CDR_LOCK_DET_EN
  localparam int LC_W = $clog2(LOCK_CNT + 1);
  localparam logic [LC_W-1:0] LC_MAX = LC_W'(LOCK_CNT);

  logic [LC_W-1:0] lock_cnt;

  // Updated on the same edge that registers the decision, so o_lock tracks o_valid.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lock_cnt <= '0;
    end else if (i_clr) begin
      lock_cnt <= '0;
    end else if (window_close) begin
      if (dec_next != DEC_NONE) begin
        lock_cnt <= '0;
      end else if (lock_cnt != LC_MAX) begin
        lock_cnt <= lock_cnt + LC_W'(1);
      end
    end
  end

  assign o_lock = (lock_cnt == LC_MAX);
`else
  assign o_lock = 1'b0;
`endif

endmodule

// File: tb/tb_aibio_cdr_phdet_filter.sv
// Self-checking bench for aibio_cdr_phdet_filter; directed scenarios plus a random run
// against a window-sum reference model. Lock checks follow AIBIO_CDR_LOCK_DET_EN.
module tb_aibio_cdr_phdet_filter;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_en;
  logic       i_clr;
  logic [3:0] i_phdet;
  logic [3:0] i_ch_mask;
  logic [7:0] i_thr;
  logic       o_valid;
  logic       o_up;
  logic       o_dn;
  logic [7:0] o_acc;
  logic       o_lock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: running window sum, enabled-sample count, last result.
  int   m_sum, m_n, m_acc, m_lc;
  logic m_valid, m_up, m_dn;

  aibio_cdr_phdet_filter #(
    .NCH(4), .WIN_W(4), .THR_W(8), .LOCK_CNT(8)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_en      (i_en),
    .i_clr     (i_clr),
    .i_phdet   (i_phdet),
    .i_ch_mask (i_ch_mask),
    .i_thr     (i_thr),
    .o_valid   (o_valid),
    .o_up      (o_up),
    .o_dn      (o_dn),
    .o_acc     (o_acc),
    .o_lock    (o_lock)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic exp_lock();
`ifdef AIBIO_CDR_LOCK_DET_EN
    return (m_lc == 8);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int acc_int();
    return int'($signed(o_acc));
  endfunction

  task automatic model_reset();
    m_sum = 0; m_n = 0; m_acc = 0; m_lc = 0;
    m_valid = 1'b0; m_up = 1'b0; m_dn = 1'b0;
  endtask

  // Drive one cycle at the falling edge, advance the model, return at the next falling edge.
  task automatic step(input logic en, input logic clr, input logic [3:0] ph);
    int d;
    i_en = en; i_clr = clr; i_phdet = ph;
    m_valid = 1'b0; m_up = 1'b0; m_dn = 1'b0;
    if (clr) begin
      m_sum = 0; m_n = 0; m_lc = 0;
    end else if (en) begin
      d = 2 * $countones(ph & i_ch_mask) - $countones(i_ch_mask);
      m_sum += d;
      m_n++;
      if (m_n == 16) begin
        m_valid = 1'b1;
        m_acc   = m_sum;
        m_up    = (m_sum >= int'(i_thr));
        m_dn    = !m_up && (m_sum <= -int'(i_thr));
        if (m_up || m_dn) m_lc = 0;
        else if (m_lc < 8) m_lc++;
        m_sum = 0; m_n = 0;
      end
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    n_cmp++;
    if ({o_valid, o_up, o_dn, o_acc, o_lock} !== 12'h000) begin
      n_bad++;
      $display("[TB] FAIL reset_init: got v=%b u=%b d=%b acc=%0d lock=%b, want all 0",
               o_valid, o_up, o_dn, acc_int(), o_lock);
    end
    i_reset = 1'b0;
    model_reset();
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 4'hF);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 4'hF);
    i_reset = 1'b1;
    #1;
    n_cmp++;
    if ({o_valid, o_up, o_dn, o_acc, o_lock} !== 12'h000) begin
      n_bad++;
      $display("[TB] FAIL reset_midwin: got v=%b u=%b d=%b acc=%0d lock=%b, want all 0",
               o_valid, o_up, o_dn, acc_int(), o_lock);
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    model_reset();
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 4'hF);
      n_cmp++;
      if (o_valid !== (k == 15)) begin
        n_bad++;
        $display("[TB] FAIL reset_first_valid: step %0d got valid=%b want %b", k + 1, o_valid, k == 15);
      end
    end
  endtask

  task automatic test_all_up();
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 4'hF);
    n_cmp++;
    if (o_valid !== 1'b1 || o_up !== 1'b1 || o_dn !== 1'b0 || acc_int() !== 64) begin
      n_bad++;
      $display("[TB] FAIL all_up: got v=%b u=%b d=%b acc=%0d, want 1 1 0 64", o_valid, o_up, o_dn, acc_int());
    end
    step(1'b0, 1'b0, 4'h0);
    n_cmp++;
    if (o_valid !== 1'b0 || o_up !== 1'b0 || acc_int() !== 64) begin
      n_bad++;
      $display("[TB] FAIL pulse_hold: got v=%b u=%b acc=%0d, want 0 0 64", o_valid, o_up, acc_int());
    end
  endtask

  task automatic test_down_and_mask();
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 4'h1);
    n_cmp++;
    if (o_valid !== 1'b1 || o_up !== 1'b0 || o_dn !== 1'b1 || acc_int() !== -32) begin
      n_bad++;
      $display("[TB] FAIL down: got v=%b u=%b d=%b acc=%0d, want 1 0 1 -32", o_valid, o_up, o_dn, acc_int());
    end
    i_ch_mask = 4'h1;
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 4'h1);
    n_cmp++;
    if (o_valid !== 1'b1 || o_up !== 1'b1 || o_dn !== 1'b0 || acc_int() !== 16) begin
      n_bad++;
      $display("[TB] FAIL mask1: got v=%b u=%b d=%b acc=%0d, want 1 1 0 16", o_valid, o_up, o_dn, acc_int());
    end
    i_ch_mask = 4'hF;
  endtask

  task automatic test_lock();
    logic want;
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 4'h3);
`ifdef AIBIO_CDR_LOCK_DET_EN
      want = (w == 7);
`else
      want = 1'b0;
`endif
      n_cmp++;
      if (o_valid !== 1'b1 || o_up !== 1'b0 || o_dn !== 1'b0 || acc_int() !== 0 || o_lock !== want) begin
        n_bad++;
        $display("[TB] FAIL deadband_win%0d: got v=%b u=%b d=%b acc=%0d lock=%b, want 1 0 0 0 %b",
                 w, o_valid, o_up, o_dn, acc_int(), o_lock, want);
      end
    end
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 4'hF);
    n_cmp++;
    if (o_lock !== 1'b0 || o_up !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL lock_clear: got lock=%b up=%b, want 0 1", o_lock, o_up);
    end
  endtask

  task automatic test_thr_zero_and_mask_zero();
    i_thr = 8'd0;
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 4'h3);
    n_cmp++;
    if (o_valid !== 1'b1 || o_up !== 1'b1 || o_dn !== 1'b0 || acc_int() !== 0) begin
      n_bad++;
      $display("[TB] FAIL thr_zero: got v=%b u=%b d=%b acc=%0d, want 1 1 0 0", o_valid, o_up, o_dn, acc_int());
    end
    i_ch_mask = 4'h0;
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 4'($urandom));
    n_cmp++;
    if (o_valid !== 1'b1 || o_up !== 1'b1 || o_dn !== 1'b0 || acc_int() !== 0) begin
      n_bad++;
      $display("[TB] FAIL mask0_thr0: got v=%b u=%b d=%b acc=%0d, want 1 1 0 0", o_valid, o_up, o_dn, acc_int());
    end
    i_thr = 8'd4;
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 4'($urandom));
    n_cmp++;
    if (o_valid !== 1'b1 || o_up !== 1'b0 || o_dn !== 1'b0 || acc_int() !== 0) begin
      n_bad++;
      $display("[TB] FAIL mask0_thr4: got v=%b u=%b d=%b acc=%0d, want 1 0 0 0", o_valid, o_up, o_dn, acc_int());
    end
    i_ch_mask = 4'hF;
  endtask

  task automatic test_enable_hold();
    int steps;
    steps = 0;
    for (int k = 0; k < 21; k++) begin
      if (k >= 3 && k < 8) step(1'b0, 1'b0, 4'hF);
      else step(1'b1, 1'b0, 4'($urandom));
      steps++;
      n_cmp++;
      if (o_valid !== (steps == 21)) begin
        n_bad++;
        $display("[TB] FAIL en_hold_valid: step %0d got valid=%b want %b", steps, o_valid, steps == 21);
      end
    end
    n_cmp++;
    if (acc_int() !== m_acc || o_up !== m_up || o_dn !== m_dn) begin
      n_bad++;
      $display("[TB] FAIL en_hold_acc: got acc=%0d u=%b d=%b, want %0d %b %b",
               acc_int(), o_up, o_dn, m_acc, m_up, m_dn);
    end
  endtask

  task automatic test_clear();
    int held;
    held = acc_int();
    for (int k = 0; k < 15; k++) step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'h0);
    n_cmp++;
    if (o_valid !== 1'b0 || acc_int() !== held || o_lock !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL clr_discard: got v=%b acc=%0d lock=%b, want 0 %0d 0", o_valid, acc_int(), o_lock, held);
    end
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 4'hE);
      n_cmp++;
      if (o_valid !== (k == 15)) begin
        n_bad++;
        $display("[TB] FAIL clr_restart: step %0d got valid=%b want %b", k + 1, o_valid, k == 15);
      end
    end
    n_cmp++;
    if (acc_int() !== 32 || o_up !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL clr_restart_acc: got acc=%0d up=%b, want 32 1", acc_int(), o_up);
    end
  endtask

  task automatic test_random();
    logic en, clr;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 31) == 0) i_ch_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) i_thr = 8'($urandom_range(0, 24));
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 49) == 0);
      step(en, clr, 4'($urandom));
      n_cmp++;
      if (o_valid !== m_valid || o_up !== m_up || o_dn !== m_dn || acc_int() !== m_acc || o_lock !== exp_lock()) begin
        n_bad++;
        $display("[TB] FAIL random step %0d: got v=%b u=%b d=%b acc=%0d lock=%b, want %b %b %b %0d %b",
                 k, o_valid, o_up, o_dn, acc_int(), o_lock, m_valid, m_up, m_dn, m_acc, exp_lock());
      end
    end
  endtask

  initial begin
    i_reset = 1'b1; i_en = 1'b0; i_clr = 1'b0;
    i_phdet = 4'h0; i_ch_mask = 4'hF; i_thr = 8'd4;
    model_reset();
    test_reset();
    test_all_up();
    test_down_and_mask();
    test_lock();
    test_thr_zero_and_mask_zero();
    test_enable_hold();
    test_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
